// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 8N1 UART receiver with 2-flop line synchronizer and valid/ready output
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx #(
   parameter int CLK_FREQ  = 60_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam logic [15:0] BIT_END      = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_END     = 16'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t      state, state_next;
   logic        rxd_meta, rxd_s;
   logic [15:0] timer, timer_next;
   logic [2:0]  bit_idx, bit_idx_next;
   logic [7:0]  shift, shift_next;
   logic        deliver, deliver_next;
   logic        ferr_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
         state    <= IDLE;
         timer    <= 16'd0;
         bit_idx  <= 3'd0;
         shift    <= 8'h00;
         deliver  <= 1'b0;
      end else begin
         rxd_meta <= uart_rxd;
         rxd_s    <= rxd_meta;
         state    <= state_next;
         timer    <= timer_next;
         bit_idx  <= bit_idx_next;
         shift    <= shift_next;
         deliver  <= deliver_next;
      end
   end

   // Timer restarts at mid-start, so every later compare lands mid-bit.
   always_comb begin
      state_next   = state;
      timer_next   = timer + 16'd1;
      bit_idx_next = bit_idx;
      shift_next   = shift;
      deliver_next = 1'b0;
      ferr_next    = 1'b0;
      case (state)
         IDLE: begin
            timer_next = 16'd0;
            if (!rxd_s) state_next = START;
         end
         START: begin
            if (timer == HALF_END) begin
               timer_next   = 16'd0;
               bit_idx_next = 3'd0;
               state_next   = rxd_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (timer == BIT_END) begin
               timer_next   = 16'd0;
               shift_next   = {rxd_s, shift[7:1]};
               bit_idx_next = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_next = STOP;
            end
         end
         STOP: begin
            if (timer == BIT_END) begin
               timer_next = 16'd0;
               if (rxd_s) begin
                  deliver_next = 1'b1;
                  state_next   = IDLE;
               end else begin
                  ferr_next  = 1'b1;
                  state_next = BREAK;
               end
            end
         end
         BREAK: begin
            timer_next = 16'd0;
            if (rxd_s) state_next = IDLE;
         end
         default: begin
            timer_next = 16'd0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr_next;
         overrun   <= 1'b0;
         if (deliver) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shift;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : directed self-checking bench for uart_rx at 16 clocks per bit
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

   localparam real BIT_NS = 160.0;

   logic       clk = 1'b0;
   logic       rst;
   logic       uart_rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] got_q[$];
   int   ferr_cnt, ovr_cnt, cyc, first_valid_cyc;
   logic busy_seen, prev_valid;

   uart_rx #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000)) dut (
      .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
      .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   // Observes handshakes and pulses on the falling edge, away from the DUT edge.
   always @(negedge clk) begin
      if (rx_valid === 1'b1 && rx_ready === 1'b1) got_q.push_back(rx_data);
      if (frame_err === 1'b1) ferr_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
      if (busy === 1'b1) busy_seen = 1'b1;
      if (rx_valid === 1'b1 && prev_valid !== 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      prev_valid = rx_valid;
   end

   task automatic clear_mon();
      got_q.delete();
      ferr_cnt        = 0;
      ovr_cnt         = 0;
      busy_seen       = 1'b0;
      first_valid_cyc = -1;
   endtask

   // Line is left at the stop value so a low stop bit can be stretched.
   task automatic send_byte(input logic [7:0] b, input real bit_ns, input logic stop_val);
      uart_rxd = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         #(bit_ns);
      end
      uart_rxd = stop_val;
      #(bit_ns);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses: got ferr=%b ovr=%b want 0 0", frame_err, overrun); end
      rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_basic();
      int t0;
      clear_mon();
      rx_ready = 1'b1;
      @(negedge clk);
      t0 = cyc;
      send_byte(8'hA5, BIT_NS, 1'b1);
      repeat (10) @(negedge clk);
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL basic_count: got %0d bytes want 1", got_q.size()); end
      else begin
         checks++; if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", got_q[0]); end
      end
      checks++; if (first_valid_cyc - t0 < 154 || first_valid_cyc - t0 > 156) begin errors++; $display("FAIL basic_latency: got %0d want 155+/-1", first_valid_cyc - t0); end
      checks++; if (ferr_cnt != 0 || ovr_cnt != 0) begin errors++; $display("FAIL basic_errs: got ferr=%0d ovr=%0d want 0 0", ferr_cnt, ovr_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_false_start();
      clear_mon();
      @(negedge clk);
      uart_rxd = 1'b0;
      repeat (5) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (40) @(negedge clk);
      checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL false_busy_seen: got %b want 1", busy_seen); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_idle: got busy=%b want 0", busy); end
      checks++; if (got_q.size() != 0 || ferr_cnt != 0) begin errors++; $display("FAIL false_outputs: got bytes=%0d ferr=%0d want 0 0", got_q.size(), ferr_cnt); end
   endtask

   task automatic test_frame_err();
      clear_mon();
      @(negedge clk);
      send_byte(8'h3C, BIT_NS, 1'b0);
      repeat (40) @(negedge clk);
      uart_rxd = 1'b1;
      #(2.0 * BIT_NS);
      send_byte(8'h81, BIT_NS, 1'b1);
      repeat (10) @(negedge clk);
      checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt); end
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL ferr_bytes: got %0d want 1", got_q.size()); end
      else begin
         checks++; if (got_q[0] !== 8'h81) begin errors++; $display("FAIL ferr_next_data: got %h want 81", got_q[0]); end
      end
      checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL ferr_rx_data: got %h want 81", rx_data); end
   endtask

   task automatic test_overrun();
      clear_mon();
      @(posedge clk); #1 rx_ready = 1'b0;
      @(negedge clk);
      send_byte(8'h11, BIT_NS, 1'b1);
      send_byte(8'h22, BIT_NS, 1'b1);
      repeat (10) @(negedge clk);
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b want 1", rx_valid); end
      checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data_held: got %h want 11", rx_data); end
      checks++; if (ovr_cnt != 1) begin errors++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt); end
      @(posedge clk); #1 rx_ready = 1'b1;
      @(posedge clk); #1 rx_ready = 1'b0;
      @(negedge clk);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", rx_valid); end
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL ovr_accepts: got %0d want 1", got_q.size()); end
      rx_ready = 1'b1;
   endtask

   task automatic test_reset_abort();
      clear_mon();
      rx_ready = 1'b1;
      @(negedge clk);
      fork
         send_byte(8'h55, BIT_NS, 1'b1);
         begin
            #(5.5 * BIT_NS);
            rst = 1'b1;
            #(5.0 * BIT_NS);
            @(negedge clk);
            rst = 1'b0;
         end
      join
      repeat (5) @(negedge clk);
      checks++; if (got_q.size() != 0 || ferr_cnt != 0 || ovr_cnt != 0) begin errors++; $display("FAIL abort_outputs: got bytes=%0d ferr=%0d ovr=%0d want 0 0 0", got_q.size(), ferr_cnt, ovr_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b want 0", busy); end
      send_byte(8'h0F, BIT_NS, 1'b1);
      repeat (10) @(negedge clk);
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL abort_resume_count: got %0d want 1", got_q.size()); end
      else begin
         checks++; if (got_q[0] !== 8'h0F) begin errors++; $display("FAIL abort_resume_data: got %h want 0f", got_q[0]); end
      end
   endtask

   task automatic test_baud(input real bit_ns);
      clear_mon();
      rx_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) send_byte(8'(i), bit_ns, 1'b1);
      repeat (20) @(negedge clk);
      checks++; if (got_q.size() != 10) begin errors++; $display("FAIL baud_count(%0.1f): got %0d want 10", bit_ns, got_q.size()); end
      else begin
         for (int i = 0; i < 10; i++) begin
            checks++; if (got_q[i] !== 8'(i)) begin errors++; $display("FAIL baud_data(%0.1f)[%0d]: got %h want %h", bit_ns, i, got_q[i], 8'(i)); end
         end
      end
      checks++; if (ferr_cnt != 0 || ovr_cnt != 0) begin errors++; $display("FAIL baud_errs(%0.1f): got ferr=%0d ovr=%0d want 0 0", bit_ns, ferr_cnt, ovr_cnt); end
   endtask

   initial begin
      uart_rxd   = 1'b1;
      rx_ready   = 1'b1;
      rst        = 1'b1;
      prev_valid = 1'b0;
      clear_mon();
      test_reset();
      test_basic();
      test_false_start();
      test_frame_err();
      test_overrun();
      test_reset_abort();
      test_baud(BIT_NS / 1.02);
      test_baud(BIT_NS / 0.98);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
